// File: rtl/locked_regfile_pkg.sv
// Shared lock-state encoding and index-width helper for the locked register file.
package regfile_pkg;

    typedef logic [1:0] lock_state_t;

    localparam lock_state_t ST_IDLE         = 2'd0;
    localparam lock_state_t ST_READ_SHARED  = 2'd1;
    localparam lock_state_t ST_WRITE_LOCKED = 2'd2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/locked_regfile_if.sv
// Per-port lock request/release bus plus per-register busy flags.
interface locked_regfile_if #(
    parameter int NUM_PHY_REGS = 64,
    parameter int TOTAL_PORTS  = 12,
    parameter int ID_WIDTH     = 6,
    parameter int DATA_WIDTH   = 32
);
    localparam int AW = regfile_pkg::idx_width(NUM_PHY_REGS);

    logic [AW-1:0]         port_addr      [TOTAL_PORTS];
    logic                  port_req_read  [TOTAL_PORTS];
    logic                  port_req_write [TOTAL_PORTS];
    logic [ID_WIDTH-1:0]   port_issue_id  [TOTAL_PORTS];
    logic                  port_release   [TOTAL_PORTS];
    logic [DATA_WIDTH-1:0] port_wdata     [TOTAL_PORTS];
    logic [DATA_WIDTH-1:0] port_rdata_out [TOTAL_PORTS];
    logic                  port_grant_out [TOTAL_PORTS];
    logic                  reg_busy_out   [NUM_PHY_REGS];
    logic                  lock_err_out   [TOTAL_PORTS];

    modport master (
        output port_addr, port_req_read, port_req_write, port_issue_id,
               port_release, port_wdata,
        input  port_rdata_out, port_grant_out, reg_busy_out, lock_err_out
    );

    modport slave (
        input  port_addr, port_req_read, port_req_write, port_issue_id,
               port_release, port_wdata,
        output port_rdata_out, port_grant_out, reg_busy_out, lock_err_out
    );

endinterface

// File: rtl/locked_regfile_cell.sv
// One physical register: lock state, reader mask, write owner, age arbiter and data.
module reg_lock_cell
    import regfile_pkg::*;
#(
    parameter int TOTAL_PORTS = 12,
    parameter int ID_WIDTH    = 6,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TOTAL_PORTS-1:0] req_rd_i,
    input  logic [TOTAL_PORTS-1:0] req_wr_i,
    input  logic [TOTAL_PORTS-1:0] rel_i,
    input  logic [ID_WIDTH-1:0]    issue_id_i [TOTAL_PORTS],
    input  logic [DATA_WIDTH-1:0]  wdata_i    [TOTAL_PORTS],
    output logic [TOTAL_PORTS-1:0] held_o,
    output logic [TOTAL_PORTS-1:0] rel_err_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   busy_o
);
    localparam int PW = idx_width(TOTAL_PORTS);

    lock_state_t           state_q, state_d;
    logic [TOTAL_PORTS-1:0] mask_q, mask_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                   win_found, win_wr, wr_found;
    logic [PW-1:0]          win_idx, wr_idx;
    logic [ID_WIDTH-1:0]    win_id, wr_id;
    logic [TOTAL_PORTS-1:0] rd_cand, wr_cand, read_ok;

    // Age order is (issue_id, port index); a port requesting both is treated as a writer.
    always_comb begin
        rd_cand   = req_rd_i & ~req_wr_i & ~mask_q;
        wr_cand   = req_wr_i & ~mask_q;
        win_found = 1'b0;
        win_wr    = 1'b0;
        win_idx   = '0;
        win_id    = '0;
        wr_found  = 1'b0;
        wr_idx    = '0;
        wr_id     = '0;
        read_ok   = '0;
        for (int unsigned p = 0; p < TOTAL_PORTS; p++) begin
            if ((rd_cand[p] || wr_cand[p]) && (!win_found || issue_id_i[p] < win_id)) begin
                win_found = 1'b1;
                win_wr    = wr_cand[p];
                win_idx   = PW'(p);
                win_id    = issue_id_i[p];
            end
            if (wr_cand[p] && (!wr_found || issue_id_i[p] < wr_id)) begin
                wr_found = 1'b1;
                wr_idx   = PW'(p);
                wr_id    = issue_id_i[p];
            end
        end
        for (int unsigned p = 0; p < TOTAL_PORTS; p++) begin
            read_ok[p] = rd_cand[p] && (!wr_found || issue_id_i[p] < wr_id ||
                         (issue_id_i[p] == wr_id && PW'(p) < wr_idx));
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        owner_d = owner_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found && win_wr) begin
                    state_d         = ST_WRITE_LOCKED;
                    owner_d         = win_idx;
                    mask_d          = '0;
                    mask_d[win_idx] = 1'b1;
                end else if (win_found) begin
                    state_d = ST_READ_SHARED;
                    mask_d  = read_ok;
                end
            end
            ST_READ_SHARED: mask_d = mask_q | read_ok;
            default: ;
        endcase
        // Releases act on the post-join holder set, so a same-edge join+release nets out.
        rel_err_o = rel_i & ~mask_d;
        if (state_d == ST_WRITE_LOCKED) begin
            if (rel_i[owner_d]) begin
                data_d  = wdata_i[owner_d];
                state_d = ST_IDLE;
                mask_d  = '0;
            end
        end else if (state_d == ST_READ_SHARED) begin
            mask_d = mask_d & ~rel_i;
            if (mask_d == '0) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            owner_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            data_q  <= data_d;
        end
    end

    assign held_o = mask_q;
    assign data_o = data_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/locked_regfile.sv
// Register file with per-register reader/writer locks arbitrated by issue age.
module locked_regfile
    import regfile_pkg::*;
#(
    parameter int NUM_PHY_REGS = 64,
    parameter int TOTAL_PORTS  = 12,
    parameter int ID_WIDTH     = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int ZERO_REG     = 1
) (
    input  logic         clk,
    input  logic         rst,
    locked_regfile_if.slave bus
);
    localparam int AW = idx_width(NUM_PHY_REGS);
    localparam logic [AW:0] NUM_W = (AW+1)'(NUM_PHY_REGS);

    logic [TOTAL_PORTS-1:0] in_rng, zero_hit, any_req, grant, err_d, err_q;
    logic [TOTAL_PORTS-1:0] held_m   [NUM_PHY_REGS];
    logic [TOTAL_PORTS-1:0] cell_err [NUM_PHY_REGS];
    logic [DATA_WIDTH-1:0]  cell_data[NUM_PHY_REGS];
    logic [ID_WIDTH-1:0]    ids      [TOTAL_PORTS];
    logic [DATA_WIDTH-1:0]  wdata    [TOTAL_PORTS];

    assign ids   = bus.port_issue_id;
    assign wdata = bus.port_wdata;

    always_comb begin
        for (int unsigned p = 0; p < TOTAL_PORTS; p++) begin
            in_rng[p]   = ({1'b0, bus.port_addr[p]} < NUM_W);
            zero_hit[p] = (ZERO_REG != 0) && (bus.port_addr[p] == '0);
            any_req[p]  = bus.port_req_read[p] | bus.port_req_write[p];
        end
    end

    for (genvar r = 0; r < NUM_PHY_REGS; r++) begin : g_reg
        if (ZERO_REG != 0 && r == 0) begin : g_zero
            assign held_m[r]           = '0;
            assign cell_err[r]         = '0;
            assign cell_data[r]        = '0;
            assign bus.reg_busy_out[r] = 1'b0;
        end else begin : g_cell
            logic [TOTAL_PORTS-1:0] rd, wr, rel;
            always_comb begin
                for (int unsigned p = 0; p < TOTAL_PORTS; p++) begin
                    rd[p]  = in_rng[p] && bus.port_addr[p] == AW'(r) && bus.port_req_read[p];
                    wr[p]  = in_rng[p] && bus.port_addr[p] == AW'(r) && bus.port_req_write[p];
                    rel[p] = in_rng[p] && bus.port_addr[p] == AW'(r) && bus.port_release[p];
                end
            end
            reg_lock_cell #(
                .TOTAL_PORTS(TOTAL_PORTS),
                .ID_WIDTH   (ID_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .req_rd_i  (rd),
                .req_wr_i  (wr),
                .rel_i     (rel),
                .issue_id_i(ids),
                .wdata_i   (wdata),
                .held_o    (held_m[r]),
                .rel_err_o (cell_err[r]),
                .data_o    (cell_data[r]),
                .busy_o    (bus.reg_busy_out[r])
            );
        end
    end

    // Register 0 (when hard-wired) bypasses locking entirely and never errors.
    always_comb begin
        for (int unsigned p = 0; p < TOTAL_PORTS; p++) begin
            grant[p]              = 1'b0;
            err_d[p]              = 1'b0;
            bus.port_rdata_out[p] = '0;
            if (!in_rng[p]) begin
                err_d[p] = any_req[p] | bus.port_release[p];
            end else if (zero_hit[p]) begin
                grant[p] = any_req[p];
            end else begin
                grant[p] = held_m[bus.port_addr[p]][p] & any_req[p];
                if (grant[p] && bus.port_req_read[p])
                    bus.port_rdata_out[p] = cell_data[bus.port_addr[p]];
            end
            for (int unsigned r = 0; r < NUM_PHY_REGS; r++)
                err_d[p] = err_d[p] | cell_err[r][p];
            bus.port_grant_out[p] = grant[p];
            bus.lock_err_out[p]   = err_q[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

endmodule

// File: doc/locked_regfile.md
LOCKED_REGFILE -- requirements
Module: locked_regfile

Interface
REQ-001 SHALL provide parameter NUM_PHY_REGS, default 64, number of physical registers.
REQ-002 SHALL provide parameter TOTAL_PORTS, default 12, number of access ports.
REQ-003 SHALL provide parameter ID_WIDTH, default 6, issue-ID width.
REQ-004 SHALL provide parameter DATA_WIDTH, default 32, register data width.
REQ-005 SHALL provide parameter ZERO_REG, default 1; when 1, register 0 is hard-wired zero.
REQ-006 SHALL use one clock and a synchronous, active-high reset; port clk input 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port port_addr[TOTAL_PORTS], input, $clog2(NUM_PHY_REGS) bits: target register.
REQ-009 SHALL have ports port_req_read[TOTAL_PORTS] and port_req_write[TOTAL_PORTS], input, 1 bit each: lock requests.
REQ-010 SHALL have port port_issue_id[TOTAL_PORTS], input, ID_WIDTH bits: age; a smaller value is older.
REQ-011 SHALL have port port_release[TOTAL_PORTS], input, 1 bit: drops the held lock on port_addr.
REQ-012 SHALL have port port_wdata[TOTAL_PORTS], input, DATA_WIDTH bits: write data, sampled at release.
REQ-013 SHALL have port port_rdata_out[TOTAL_PORTS], output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port port_grant_out[TOTAL_PORTS], output, 1 bit: port holds its lock.
REQ-015 SHALL have port reg_busy_out[NUM_PHY_REGS], output, 1 bit: register is not IDLE.
REQ-016 SHALL have port lock_err_out[TOTAL_PORTS], output, 1 bit: one-cycle registered error pulse.

Function
REQ-017 SHALL keep, per register, a state in {IDLE, READ_SHARED, WRITE_LOCKED}, a TOTAL_PORTS-bit reader mask, an owner index, and data.
REQ-018 SHALL arbitrate at the clock edge; a lock acquired at edge t drives grant from cycle t+1 (1-cycle latency).
REQ-019 SHALL choose the IDLE winner as the requester with the smallest issue_id; ties go to the lowest port index.
REQ-020 SHALL move a register to WRITE_LOCKED with owner = winner when the IDLE winner is a write.
REQ-021 SHALL move a register to READ_SHARED when the IDLE winner is a read, setting mask bits for every read requester older than the oldest pending write.
REQ-022 SHALL let a new reader join READ_SHARED only when it is older than every pending write requester, so writes are not starved.
REQ-023 SHALL drive port_grant_out[p] = lock held by p AND (req_read[p] OR req_write[p]).
REQ-024 SHALL retain a held lock until release, even when the request deasserts.
REQ-025 SHALL clear the mask bit on release in READ_SHARED; an empty mask moves the register to IDLE at that edge, and re-arbitration occurs at the next edge.
REQ-026 SHALL, on owner release in WRITE_LOCKED, write port_wdata[owner] to data and move to IDLE at that edge.
REQ-027 SHALL drive port_rdata_out[p] = data when granted and req_read, else 0; a write owner reading sees the pre-write value.
REQ-028 SHALL process joins and releases arriving in the same edge together, with the release applied after the join.
REQ-029 SHALL ignore a release from a non-holder and pulse lock_err_out[p] in the next cycle.
REQ-030 SHALL never grant an address >= NUM_PHY_REGS and SHALL pulse lock_err_out for any request to it.
REQ-031 SHALL, with ZERO_REG=1, grant any register-0 request combinationally in the same cycle, return 0, discard writes, and hold reg_busy_out[0]=0.

Reset
REQ-032 SHALL, when rst is asserted at a clock edge, set all states IDLE, clear masks and owners, zero data, and drive grant, busy and err outputs to 0.
REQ-033 SHALL, on rst asserted mid-lock, drop all locks without committing pending wdata.

Structure
REQ-034 SHALL define lock_state_t in regfile_pkg; widths remain module parameters.
REQ-035 SHALL implement one sub-module, reg_lock_cell, per register, holding the state, arbiter and data.

Verification
REQ-036 SHALL test reads with ids 5, 3 (ports 0, 1) to r7 while idle -> both granted the next cycle; r7 busy.
REQ-037 SHALL test write id 2 (port 2) vs read id 4 (port 3) on r9 -> port 2 granted; release with wdata 0xDEADBEEF -> port 3 granted, reads 0xDEADBEEF.
REQ-038 SHALL test READ_SHARED held by id 8 with write id 6 pending -> a new read id 7 waits; the write is granted after the last release.
REQ-039 SHALL test release from port 4, a non-holder of r3 -> lock_err_out[4]=1 for one cycle; state unchanged.
REQ-040 SHALL test write owner on r5, then rst pulsed before release -> r5 reads 0; all grants 0.
REQ-041 SHALL test ZERO_REG=1 with write 0x1234 to r0 -> granted the same cycle; a subsequent read returns 0.
